// File: rtl/spi_slave_regs_if.sv
// Bus bundle for spi_slave_regs: SPI pins plus the local register port.
// The slave modport is the register block's view; master is the host/SPI-master side.
interface spi_slave_regs_if;
    logic       ce;
    logic       sck;
    logic       mosi;
    logic       miso;
    logic       loc_we;
    logic [2:0] loc_addr;
    logic [7:0] loc_wdata;
    logic [7:0] loc_rdata;
    logic       spi_wr;
    logic [2:0] spi_waddr;
    logic [7:0] spi_wdata;
    logic       busy;

    modport slave (
        input  ce, sck, mosi, loc_we, loc_addr, loc_wdata,
        output miso, loc_rdata, spi_wr, spi_waddr, spi_wdata, busy
    );

    modport master (
        output ce, sck, mosi, loc_we, loc_addr, loc_wdata,
        input  miso, loc_rdata, spi_wr, spi_waddr, spi_wdata, busy
    );
endinterface

// File: rtl/spi_slave_regs.sv
// SPI mode-3 slave with an 8x8 register file and a local read/write port.
// Define SPI_SLV_AUTOINC_EN to auto-increment (mod 8) the address across burst bytes.
module spi_slave_regs #(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    spi_slave_regs_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    logic [SYNC_STAGES-1:0] ce_sync_reg;
    logic [SYNC_STAGES-1:0] sck_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        ce_sync_reg[gi]   <= 1'b0;
                        sck_sync_reg[gi]  <= 1'b0;
                        mosi_sync_reg[gi] <= 1'b0;
                    end else begin
                        ce_sync_reg[gi]   <= bus.ce;
                        sck_sync_reg[gi]  <= bus.sck;
                        mosi_sync_reg[gi] <= bus.mosi;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        ce_sync_reg[gi]   <= 1'b0;
                        sck_sync_reg[gi]  <= 1'b0;
                        mosi_sync_reg[gi] <= 1'b0;
                    end else begin
                        ce_sync_reg[gi]   <= ce_sync_reg[gi-1];
                        sck_sync_reg[gi]  <= sck_sync_reg[gi-1];
                        mosi_sync_reg[gi] <= mosi_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    logic ce_s, sck_s, mosi_s;
    logic ce_prev_reg, sck_prev_reg;
    logic ce_rise, ce_fall, sck_rise, sck_fall;

    assign ce_s     = ce_sync_reg[SYNC_STAGES-1];
    assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_reg[SYNC_STAGES-1];
    assign ce_rise  = ce_s & ~ce_prev_reg;
    assign ce_fall  = ~ce_s & ce_prev_reg;
    assign sck_rise = sck_s & ~sck_prev_reg;
    assign sck_fall = ~sck_s & sck_prev_reg;

    state_t     state_reg, state_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic [2:0] addr_reg, addr_next;
    logic [7:0] shift_in_reg, shift_in_next;
    logic [7:0] shift_out_reg, shift_out_next;
    logic       miso_reg, miso_next;
    logic       commit;
    logic [7:0] shifted;
    logic [2:0] addr_adv;
    logic [7:0] regfile_reg [0:7];
    logic       spi_wr_reg;
    logic [2:0] spi_waddr_reg;
    logic [7:0] spi_wdata_reg;
    logic [7:0] loc_rdata_reg;

    assign shifted = {shift_in_reg[6:0], mosi_s};

`ifdef SPI_SLV_AUTOINC_EN
    assign addr_adv = addr_reg + 3'd1;
`else
    assign addr_adv = addr_reg;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ce_prev_reg   <= 1'b0;
            sck_prev_reg  <= 1'b0;
            state_reg     <= IDLE;
            bit_cnt_reg   <= 3'd0;
            addr_reg      <= 3'd0;
            shift_in_reg  <= 8'h00;
            shift_out_reg <= 8'h00;
            miso_reg      <= 1'b0;
        end else begin
            ce_prev_reg   <= ce_s;
            sck_prev_reg  <= sck_s;
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            addr_reg      <= addr_next;
            shift_in_reg  <= shift_in_next;
            shift_out_reg <= shift_out_next;
            miso_reg      <= miso_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        addr_next      = addr_reg;
        shift_in_next  = shift_in_reg;
        shift_out_next = shift_out_reg;
        miso_next      = miso_reg;
        commit         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ce_rise) begin
                    state_next    = CMD;
                    bit_cnt_next  = 3'd0;
                    shift_in_next = 8'h00;
                    miso_next     = 1'b0;
                end
            end
            CMD: begin
                if (sck_rise) begin
                    shift_in_next = shifted;
                    bit_cnt_next  = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        addr_next = shifted[2:0];
                        if (shifted[7]) begin
                            state_next     = RDATA;
                            shift_out_next = regfile_reg[shifted[2:0]];
                        end else begin
                            state_next = WDATA;
                        end
                    end
                end
            end
            WDATA: begin
                if (sck_rise) begin
                    shift_in_next = shifted;
                    bit_cnt_next  = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        commit    = 1'b1;
                        addr_next = addr_adv;
                    end
                end
            end
            RDATA: begin
                // The byte is snapshotted into shift_out_reg, so later local writes cannot disturb it.
                if (sck_fall) begin
                    miso_next      = shift_out_reg[7];
                    shift_out_next = {shift_out_reg[6:0], 1'b0};
                    bit_cnt_next   = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        addr_next      = addr_adv;
                        shift_out_next = regfile_reg[addr_adv];
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_reg != IDLE && ce_fall) begin
            state_next = IDLE;
            miso_next  = 1'b0;
            commit     = 1'b0;
        end
    end

    // SPI commit takes priority over a same-cycle local write to the same entry.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_regfile
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    regfile_reg[gi] <= 8'h00;
                end else if (commit && addr_reg == 3'(gi)) begin
                    regfile_reg[gi] <= shifted;
                end else if (bus.loc_we && bus.loc_addr == 3'(gi)) begin
                    regfile_reg[gi] <= bus.loc_wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spi_wr_reg    <= 1'b0;
            spi_waddr_reg <= 3'd0;
            spi_wdata_reg <= 8'h00;
            loc_rdata_reg <= 8'h00;
        end else begin
            spi_wr_reg    <= commit;
            loc_rdata_reg <= regfile_reg[bus.loc_addr];
            if (commit) begin
                spi_waddr_reg <= addr_reg;
                spi_wdata_reg <= shifted;
            end
        end
    end

    assign bus.miso      = (state_reg == IDLE) ? 1'b0 : miso_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.spi_wr    = spi_wr_reg;
    assign bus.spi_waddr = spi_waddr_reg;
    assign bus.spi_wdata = spi_wdata_reg;
    assign bus.loc_rdata = loc_rdata_reg;
endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: writes, read bursts, wrap, abort, collision, reset.
// Expectations follow SPI_SLV_AUTOINC_EN when it is defined for the build.
module tb_spi_slave_regs;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_slave_regs_if bus_if ();

    spi_slave_regs #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [2:0] last_waddr = 3'd0;
    logic [7:0] last_wdata = 8'h00;

    always @(negedge clk) begin
        if (bus_if.spi_wr === 1'b1) begin
            wr_cnt     = wr_cnt + 1;
            last_waddr = bus_if.spi_waddr;
            last_wdata = bus_if.spi_wdata;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One mode-3 bit: drive on the falling edge, sample miso just before the rising edge.
    task automatic spi_bit(input logic tx, input logic coll, output logic rx);
        bus_if.sck  = 1'b0;
        bus_if.mosi = tx;
        tick(8);
        rx = bus_if.miso;
        bus_if.sck = 1'b1;
        if (coll) begin
            tick(2);
            bus_if.loc_we    = 1'b1;
            bus_if.loc_addr  = 3'd2;
            bus_if.loc_wdata = 8'h44;
            tick(1);
            check("coll_spi_wr", {7'd0, bus_if.spi_wr}, 8'h01);
            bus_if.loc_we = 1'b0;
            tick(5);
        end else begin
            tick(8);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, input logic coll, output logic [7:0] rx);
        logic b;
        logic [7:0] r;
        r = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], coll && (i == 0), b);
            r[i] = b;
        end
        rx = r;
    endtask

    task automatic ce_start();
        bus_if.ce = 1'b1;
        tick(8);
    endtask

    task automatic ce_end();
        bus_if.ce = 1'b0;
        tick(8);
    endtask

    task automatic loc_write(input logic [2:0] a, input logic [7:0] d);
        bus_if.loc_addr  = a;
        bus_if.loc_wdata = d;
        bus_if.loc_we    = 1'b1;
        tick(1);
        bus_if.loc_we    = 1'b0;
    endtask

    task automatic loc_read(input logic [2:0] a, output logic [7:0] d);
        bus_if.loc_addr = a;
        tick(1);
        d = bus_if.loc_rdata;
    endtask

    initial begin
        logic [7:0] rx, rx0, rx1, d;
        logic b;
        bus_if.ce        = 1'b0;
        bus_if.sck       = 1'b1;
        bus_if.mosi      = 1'b0;
        bus_if.loc_we    = 1'b0;
        bus_if.loc_addr  = 3'd0;
        bus_if.loc_wdata = 8'h00;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("rst_busy", {7'd0, bus_if.busy}, 8'h00);
        check("rst_miso", {7'd0, bus_if.miso}, 8'h00);
        check("rst_spi_wr", {7'd0, bus_if.spi_wr}, 8'h00);
        check("rst_waddr", {5'd0, bus_if.spi_waddr}, 8'h00);
        check("rst_wdata", bus_if.spi_wdata, 8'h00);
        check("rst_loc_rdata", bus_if.loc_rdata, 8'h00);
        tick(3);
        reset = 1'b1;
        tick(4);

        // Single write of 0x5A to address 3
        ce_start();
        check("busy_cmd", {7'd0, bus_if.busy}, 8'h01);
        spi_byte(8'h03, 1'b0, rx);
        spi_byte(8'h5A, 1'b0, rx);
        ce_end();
        check("wr_cnt_1", 8'(wr_cnt), 8'h01);
        check("wr_waddr", {5'd0, last_waddr}, 8'h03);
        check("wr_wdata", last_wdata, 8'h5A);
        loc_read(3'd3, d);
        check("wr_reg3", d, 8'h5A);
        check("idle_busy", {7'd0, bus_if.busy}, 8'h00);
        check("idle_miso", {7'd0, bus_if.miso}, 8'h00);

        // Read burst from address 6
        loc_write(3'd6, 8'h11);
        loc_write(3'd7, 8'h22);
        ce_start();
        spi_byte(8'h86, 1'b0, rx);
        spi_byte(8'h00, 1'b0, rx0);
        spi_byte(8'h00, 1'b0, rx1);
        ce_end();
        check("rd_byte0", rx0, 8'h11);
`ifdef SPI_SLV_AUTOINC_EN
        check("rd_byte1", rx1, 8'h22);
`else
        check("rd_byte1", rx1, 8'h11);
`endif
        check("rd_idle_miso", {7'd0, bus_if.miso}, 8'h00);

        // Write burst starting at address 7
        ce_start();
        spi_byte(8'h07, 1'b0, rx);
        spi_byte(8'hAA, 1'b0, rx);
        spi_byte(8'hBB, 1'b0, rx);
        ce_end();
        check("wrap_wr_cnt", 8'(wr_cnt), 8'h03);
        loc_read(3'd7, d);
`ifdef SPI_SLV_AUTOINC_EN
        check("wrap_reg7", d, 8'hAA);
        loc_read(3'd0, d);
        check("wrap_reg0", d, 8'hBB);
`else
        check("wrap_reg7", d, 8'hBB);
        loc_read(3'd0, d);
        check("wrap_reg0", d, 8'h00);
`endif

        // Read byte is captured at load time despite a later local write
        ce_start();
        spi_byte(8'h83, 1'b0, rx);
        loc_write(3'd3, 8'hFF);
        spi_byte(8'h00, 1'b0, rx0);
        ce_end();
        check("snap_rx", rx0, 8'h5A);
        loc_read(3'd3, d);
        check("snap_reg3", d, 8'hFF);

        // Abort after 5 data bits
        ce_start();
        spi_byte(8'h04, 1'b0, rx);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0, b);
        bus_if.ce = 1'b0;
        tick(4);
        check("abort_busy", {7'd0, bus_if.busy}, 8'h00);
        check("abort_wr_cnt", 8'(wr_cnt), 8'h03);
        loc_read(3'd4, d);
        check("abort_reg4", d, 8'h00);
        tick(4);

        // SPI commit and local write to address 2 in the same clk
        ce_start();
        spi_byte(8'h02, 1'b0, rx);
        spi_byte(8'h33, 1'b1, rx);
        ce_end();
        check("coll_wr_cnt", 8'(wr_cnt), 8'h04);
        check("coll_waddr", {5'd0, last_waddr}, 8'h02);
        loc_read(3'd2, d);
        check("coll_reg2", d, 8'h33);

        // Reset in the middle of a read of address 7 (bit5 of 0xAA/0xBB is 1)
        ce_start();
        spi_byte(8'h87, 1'b0, rx);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, 1'b0, b);
        check("pre_rst_miso", {7'd0, bus_if.miso}, 8'h01);
        reset = 1'b0;
        #1;
        check("mid_rst_miso", {7'd0, bus_if.miso}, 8'h00);
        check("mid_rst_busy", {7'd0, bus_if.busy}, 8'h00);
        check("mid_rst_wdata", bus_if.spi_wdata, 8'h00);
        bus_if.ce  = 1'b0;
        bus_if.sck = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(4);
        for (int i = 0; i < 8; i++) begin
            loc_read(3'(i), d);
            check($sformatf("rst_reg%0d", i), d, 8'h00);
        end

        // Fresh transaction after reset
        ce_start();
        spi_byte(8'h01, 1'b0, rx);
        spi_byte(8'h7E, 1'b0, rx);
        ce_end();
        loc_read(3'd1, d);
        check("recover_reg1", d, 8'h7E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_slave_regs.md
SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

Interface
REQ-001 The block SHALL have these ports, each listed as name, direction, width, meaning.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- ce  in  1  SPI chip enable, active-high.
- sck  in  1  SPI clock; idles high; mode 3.
- mosi  in  1  serial data from master, MSB first.
- miso  out  1  serial data to master, MSB first.
- loc_we  in  1  local write strobe.
- loc_addr  in  3  local register address, shared by local read and write.
- loc_wdata  in  8  local write data.
- loc_rdata  out  8  local read data, registered.
- spi_wr  out  1  one-clk pulse when an SPI write commits.
- spi_waddr  out  3  address of the committed SPI write.
- spi_wdata  out  8  data of the committed SPI write.
- busy  out  1  high while a transaction is in progress.

REQ-002 The block SHALL have one parameter: SYNC_STAGES, default 2, the number of synchronizer flops on ce, sck and mosi.

Function
REQ-003 ce, sck and mosi SHALL be synchronized into clk; clk SHALL be at least 8x the sck frequency.
- Edges are detected on the synchronized sck.
- Latency from a pin edge to its detected event SHALL be SYNC_STAGES+1 clk.

REQ-004 Register file: 8 x 8-bit entries, all 0x00 after reset.

REQ-005 mosi SHALL be sampled on detected sck rising edges. miso SHALL update on detected sck falling edges.

REQ-006 State machine: IDLE, CMD, WDATA, RDATA.
- IDLE -> CMD on ce rise.
- Any state -> IDLE on ce fall.

REQ-007 In CMD, 8 bits SHALL be shifted in; bit7 = R/nW, bits2:0 = start address, bits6:3 ignored.
- After the 8th rising edge: go to RDATA if bit7=1, else WDATA.

REQ-008 WDATA commit: after each 8th rising edge, write the byte to regfile[addr].
- Pulse spi_wr for 1 clk, with spi_waddr = addr and spi_wdata = the byte.
- Then advance addr per REQ-015.

REQ-009 RDATA:
- At CMD completion, load the shift register with regfile[start address].
- Present bit7 on miso at the next detected falling edge, then shift on each following falling edge.
- After each 8 bits, reload from the next address per REQ-015.

REQ-010 miso SHALL be 0 whenever the state is IDLE.

REQ-011 busy SHALL equal (state != IDLE).

REQ-012 ce falling mid-byte SHALL discard the partial byte, with no write and no spi_wr. Bit and address counters SHALL reset on the next ce rise.

REQ-013 sck edges while ce is low SHALL be ignored.

REQ-014 Local access:
- loc_rdata <= regfile[loc_addr] every clk, 1-cycle latency.
- loc_we writes regfile[loc_addr] <= loc_wdata.
- If an SPI commit and loc_we target the same address in the same clk, the SPI write wins. Different addresses both write.

REQ-015 Address advance SHALL be 3-bit modulo 8 (7 wraps to 0) when SPI_SLV_AUTOINC_EN is defined. Otherwise the address stays at the command start address.

REQ-016 A read byte SHALL be captured at its load time; a later local write does not alter bits already being shifted.

Reset
REQ-017 While reset=0, asynchronously:
- state = IDLE; miso = 0; busy = 0; spi_wr = 0.
- spi_waddr = 0; spi_wdata = 0x00; loc_rdata = 0x00.
- Regfile, synchronizers and counters cleared.

REQ-018 Reset asserted mid-transaction SHALL abort it. After release, the block SHALL wait for a fresh ce rise.

Configuration
REQ-019 Macro SPI_SLV_AUTOINC_EN:
- Defined: multi-byte bursts auto-increment the address with wrap.
- Undefined: all bytes of a burst access the start address, and the increment logic is absent.

Verification
REQ-020 Write: ce=1, mosi 0x03, 0x5A, ce=0 -> regfile[3]=0x5A; one spi_wr pulse with waddr=3, wdata=0x5A; loc_addr=3 -> loc_rdata=0x5A.

REQ-021 Read burst: preload regfile[6]=0x11 and [7]=0x22 locally; mosi 0x86 then 16 clocks -> miso 0x11 then 0x22 (AUTOINC) or 0x11, 0x11 (no AUTOINC).

REQ-022 Wrap: write burst at 0x07 with 0xAA, 0xBB -> [7]=0xAA, [0]=0xBB (AUTOINC).

REQ-023 Abort: ce falls after 5 data bits -> no spi_wr, regfile unchanged, busy=0 within SYNC_STAGES+2 clk.

REQ-024 Collision: SPI commit to addr 2 with 0x33 in the same clk as loc_we to addr 2 with 0x44 -> regfile[2]=0x33.

REQ-025 Reset mid-read: reset=0 during RDATA -> miso=0, busy=0, regfile all 0x00.
